// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package multdiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/multdiv_if.sv
// Pipeline/datapath-facing signal bundle of the multiply/divide controller.
interface multdiv_if #(
  parameter int CNT_W = multdiv_pkg::DEF_CNT_W
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             divisor_zero;
  logic             mult_ovf;
  logic             mplier_zero;
  logic             ld;
  logic             step;
  logic             fix;
  logic             op_div;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             data_resultRDY;
  logic             data_exception;

  modport master (
    output ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf, mplier_zero,
    input  ld, step, fix, op_div, count, busy, data_resultRDY, data_exception
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf, mplier_zero,
    output ld, step, fix, op_div, count, busy, data_resultRDY, data_exception
  );
endinterface

// File: rtl/multdiv_counter.sv
// Iteration counter: synchronous clear, enable, saturates at the terminal count WIDTH-1.
module multdiv_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == LAST);
endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared shift-add multiplier / restoring divider datapath.
// Optional early multiply termination on mplier_zero: define MULTDIV_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | waiting for a ctrl_MULT / ctrl_DIV pulse
// LOAD  | ld operands, clear iteration count
// RUN   | one step per cycle until terminal count (or divide-by-zero abort)
// FIX   | final sign correction, capture overflow exception
// DONE  | data_resultRDY pulse, stall released
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic      clock,
  input logic      reset,
  multdiv_if.slave bus
);
  state_t           state_q, state_d;
  logic             op_div_q, op_div_d;
  logic             exc_q, exc_d;
  logic             start, start_op, div_zero, run_step, early, tc;
  logic [CNT_W-1:0] count;

  assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
  assign start_op = bus.ctrl_MULT ? OP_MULT : OP_DIV;
  assign div_zero = (op_div_q == OP_DIV) & bus.divisor_zero;
  assign run_step = (state_q == RUN) & ~div_zero;

`ifdef MULTDIV_EARLY_TERM_EN
  assign early = (op_div_q == OP_MULT) & bus.mplier_zero;
`else
  logic unused_mplier_zero;
  assign unused_mplier_zero = bus.mplier_zero;
  assign early = 1'b0;
`endif

  multdiv_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_counter (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == LOAD),
    .en    (run_step),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_div_q <= OP_MULT;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      exc_q    <= exc_d;
    end
  end

  // A start pulse in any state restarts; the pending result is dropped.
  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    exc_d    = exc_q;
    if (start) begin
      state_d  = LOAD;
      op_div_d = start_op;
      exc_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        LOAD: state_d = RUN;
        RUN: begin
          if (div_zero) begin
            state_d = DONE;
            exc_d   = 1'b1;
          end else if (early || tc) begin
            state_d = FIX;
          end
        end
        FIX: begin
          state_d = DONE;
          exc_d   = (op_div_q == OP_DIV) ? 1'b0 : bus.mult_ovf;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.ld             = (state_q == LOAD);
  assign bus.step           = run_step;
  assign bus.fix            = (state_q == FIX);
  assign bus.op_div         = op_div_q;
  assign bus.count          = count;
  assign bus.busy           = (state_q == LOAD) | (state_q == RUN) | (state_q == FIX);
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.data_exception = exc_q & (state_q == DONE);
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: vector table plus restart/abort sequences.
module tb_multdiv_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nvec  = 0;
  int   nerr  = 0;

  multdiv_if #(.CNT_W(CNT_W)) bus ();

  multdiv_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   cyc;
    logic exc;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic mult, div, dz, ovf, mz;
    logic exp_op;
    int   exp_steps;
    int   exp_fix;
    int   exp_cnt;
    int   exp_rdy;
    logic exp_exc;
  } vec_t;

  function automatic vec_t mk(input logic m, d, dz, ovf, mz, op,
                              input int steps, fixc, cnt, rdy, input logic exc);
    vec_t v;
    v.mult = m; v.div = d; v.dz = dz; v.ovf = ovf; v.mz = mz; v.exp_op = op;
    v.exp_steps = steps; v.exp_fix = fixc; v.exp_cnt = cnt; v.exp_rdy = rdy; v.exp_exc = exc;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    nvec++;
    nerr++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input int cyc, input logic exc);
    exp_t e;
    e.cyc = cyc;
    e.exc = exc;
    exp_q.push_back(e);
  endtask

  function automatic int outs_word();
    return int'({bus.ld, bus.step, bus.fix, bus.op_div, bus.busy,
                 bus.data_resultRDY, bus.data_exception, bus.count});
  endfunction

  // Cycle n is the period following clock edge n-1; edge 0 samples the start pulse.
  task automatic apply(input int idx, input vec_t v);
    int   steps = 0, ld_cyc = 0, fix_cyc = 0, fix_cnt = -1, rdy_seen = 0;
    int   op_at_ld = -1, busy_bad = 0, exc_bad = 0;
    exp_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clock);
    bus.ctrl_MULT    = v.mult;
    bus.ctrl_DIV     = v.div;
    bus.divisor_zero = v.dz;
    bus.mult_ovf     = v.ovf;
    bus.mplier_zero  = v.mz;
    push_exp(v.exp_rdy, v.exp_exc);
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (bus.ld && ld_cyc == 0) begin
        ld_cyc   = c;
        op_at_ld = int'(bus.op_div);
      end
      if (bus.step) steps++;
      if (bus.fix) begin
        fix_cyc = c;
        fix_cnt = int'(bus.count);
      end
      if (bus.data_exception && !bus.data_resultRDY) exc_bad++;
      if (bus.data_resultRDY) begin
        rdy_seen++;
        check({tag, "_busy_at_rdy"}, int'(bus.busy), 0);
        if (exp_q.size() == 0) begin
          fail({tag, "_unexpected_rdy"}, c, 0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_rdy_cycle"}, c, e.cyc);
          check({tag, "_exception"}, int'(bus.data_exception), int'(e.exc));
        end
      end else if (c < v.exp_rdy && !bus.busy) begin
        busy_bad++;
      end
    end
    check({tag, "_ld_cycle"}, ld_cyc, 1);
    check({tag, "_op_div"}, op_at_ld, int'(v.exp_op));
    check({tag, "_steps"}, steps, v.exp_steps);
    check({tag, "_fix_cycle"}, fix_cyc, v.exp_fix);
    if (v.exp_fix != 0) check({tag, "_fix_count"}, fix_cnt, v.exp_cnt);
    check({tag, "_rdy_pulses"}, rdy_seen, 1);
    check({tag, "_busy_gaps"}, busy_bad, 0);
    check({tag, "_exc_unqualified"}, exc_bad, 0);
    exp_q.delete();
    bus.divisor_zero = 1'b0;
    bus.mult_ovf     = 1'b0;
    bus.mplier_zero  = 1'b0;
  endtask

  // rs_cyc: edge carrying a second start pulse (0 = none); ab_cyc: cycle where reset is asserted.
  task automatic seq(input string tag, input logic first_div, input int rs_cyc,
                     input logic rs_div, input int ab_cyc, input int ncyc);
    int   ld_n = 0, ld_bad = 0, exc_bad = 0;
    exp_t e;
    @(negedge clock);
    bus.ctrl_MULT = ~first_div;
    bus.ctrl_DIV  = first_div;
    push_exp(WIDTH + 3, 1'b0);
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      if (bus.ld) begin
        ld_n++;
        if (c == 1) check({tag, "_op_first"}, int'(bus.op_div), int'(first_div));
        else if (rs_cyc != 0 && c == rs_cyc + 1) check({tag, "_op_restart"}, int'(bus.op_div), int'(rs_div));
        else ld_bad++;
      end
      if (bus.data_exception && !bus.data_resultRDY) exc_bad++;
      if (bus.data_resultRDY) begin
        if (exp_q.size() == 0) begin
          fail({tag, "_unexpected_rdy"}, c, 0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_rdy_cycle"}, c, e.cyc);
        end
      end
      if (c == rs_cyc) begin
        bus.ctrl_MULT = ~rs_div;
        bus.ctrl_DIV  = rs_div;
        exp_q.delete();
        push_exp(rs_cyc + WIDTH + 3, 1'b0);
      end
      if (c == ab_cyc) begin
        check({tag, "_busy_before_abort"}, int'(bus.busy), 1);
        reset = 1'b0;
        #1;
        check({tag, "_outs_in_reset"}, outs_word(), 0);
        exp_q.delete();
      end
      if (ab_cyc != 0 && c == ab_cyc + 2) reset = 1'b1;
    end
    check({tag, "_ld_count"}, ld_n, (rs_cyc != 0) ? 2 : 1);
    check({tag, "_ld_stray"}, ld_bad, 0);
    check({tag, "_exc_unqualified"}, exc_bad, 0);
    check({tag, "_pending_results"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    bus.ctrl_MULT    = 1'b0;
    bus.ctrl_DIV     = 1'b0;
    bus.divisor_zero = 1'b0;
    bus.mult_ovf     = 1'b0;
    bus.mplier_zero  = 1'b0;

    vecs[0] = mk(1, 0, 0, 0, 0, 0, WIDTH, WIDTH + 2, WIDTH - 1, WIDTH + 3, 0);
    vecs[1] = mk(1, 0, 0, 1, 0, 0, WIDTH, WIDTH + 2, WIDTH - 1, WIDTH + 3, 1);
    vecs[2] = mk(0, 1, 0, 0, 0, 1, WIDTH, WIDTH + 2, WIDTH - 1, WIDTH + 3, 0);
    vecs[3] = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 3, 1);
    vecs[4] = mk(1, 1, 0, 0, 0, 0, WIDTH, WIDTH + 2, WIDTH - 1, WIDTH + 3, 0);
    vecs[5] = mk(1, 0, 1, 0, 0, 0, WIDTH, WIDTH + 2, WIDTH - 1, WIDTH + 3, 0);
    vecs[6] = mk(0, 1, 0, 1, 0, 1, WIDTH, WIDTH + 2, WIDTH - 1, WIDTH + 3, 0);
`ifdef MULTDIV_EARLY_TERM_EN
    vecs[7] = mk(1, 0, 0, 0, 1, 0, 1, 3, 1, 4, 0);
`else
    vecs[7] = mk(1, 0, 0, 0, 1, 0, WIDTH, WIDTH + 2, WIDTH - 1, WIDTH + 3, 0);
`endif

    repeat (3) @(negedge clock);
    check("reset_outputs", outs_word(), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_after_reset", outs_word(), 0);

    for (int i = 0; i < 8; i++) begin
      apply(i, vecs[i]);
      repeat (2) @(negedge clock);
    end

    seq("restart_busy", 1'b0, 10, 1'b1, 0, 80);
    repeat (2) @(negedge clock);
    seq("restart_done", 1'b0, WIDTH + 3, 1'b1, 0, 80);
    repeat (2) @(negedge clock);
    seq("abort_div", 1'b1, 0, 1'b0, 20, 60);
    check("idle_after_abort", outs_word(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
